// File: rtl/fetch_pc_redirect_if.sv
// Fetch-side bus of the next-PC generator: predictor hookup, execute-stage
// resolve inputs, flush and accuracy counters.
interface fetch_pc_redirect_if;
  logic        stall;
  logic        branch_predict;
  logic [31:0] pc;
  logic        btb_hit;
  logic        pred_taken_d;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        flush;
  logic [31:0] mispredict_count;
  logic [31:0] resolve_count;

  // Pipeline / predictor side drives the controls and observes the PC.
  modport master (
    output stall, branch_predict, resolve_valid, resolve_taken, resolve_target,
    input  pc, btb_hit, pred_taken_d, flush, mispredict_count, resolve_count
  );

  modport slave (
    input  stall, branch_predict, resolve_valid, resolve_taken, resolve_target,
    output pc, btb_hit, pred_taken_d, flush, mispredict_count, resolve_count
  );
endinterface

// File: rtl/fetch_pc_redirect.sv
// Fetch next-PC generator: direct-mapped BTB lookup, one-cycle D-stage copy of
// each prediction, mispredict redirect/flush and saturating accuracy counters.
module fetch_pc_redirect #(
  parameter int          BTB_IDX_W = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  fetch_pc_redirect_if.slave bus
);

  localparam int N_ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W     = 30 - BTB_IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [29:0]      target;
  } btb_data_t;

  logic [N_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  btb_data_t            btb_data_q [N_ENTRIES];
  btb_data_t            btb_data_d [N_ENTRIES];

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_dstage_q, pc_dstage_d;
  logic        pred_taken_dstage_q, pred_taken_dstage_d;
  logic [29:0] target_dstage_q, target_dstage_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;
  logic [31:0] resolve_count_q, resolve_count_d;

  logic [BTB_IDX_W-1:0] lookup_idx, update_idx;
  logic [TAG_W-1:0]     lookup_tag, update_tag;
  logic                 btb_hit;
  logic                 pred_taken;
  logic [29:0]          pred_target;
  logic                 target_match;
  logic                 mispredict;
  logic                 btb_we;
  logic [31:0]          redirect_pc;
  logic                 unused_resolve_lsb;

  // Combinational BTB lookup on the current fetch PC.
  assign lookup_idx  = pc_q[BTB_IDX_W+1:2];
  assign lookup_tag  = pc_q[31:BTB_IDX_W+2];
  assign btb_hit     = btb_valid_q[lookup_idx] && (btb_data_q[lookup_idx].tag == lookup_tag);
  assign pred_taken  = btb_hit && bus.branch_predict;
  assign pred_target = btb_data_q[lookup_idx].target;

  // Resolve check against the prediction captured for the D-stage slot.
  assign target_match = (bus.resolve_target[31:2] == target_dstage_q);
  assign mispredict   = bus.resolve_valid &&
                        ((bus.resolve_taken != pred_taken_dstage_q) ||
                         (bus.resolve_taken && pred_taken_dstage_q && !target_match));
  assign redirect_pc  = bus.resolve_taken ? {bus.resolve_target[31:2], 2'b00}
                                          : pc_dstage_q + 32'd4;

  assign update_idx = pc_dstage_q[BTB_IDX_W+1:2];
  assign update_tag = pc_dstage_q[31:BTB_IDX_W+2];
  assign btb_we     = bus.resolve_valid && bus.resolve_taken && !reset;

  assign unused_resolve_lsb = ^bus.resolve_target[1:0];

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    pc_d                = pc_q;
    pc_dstage_d         = pc_dstage_q;
    pred_taken_dstage_d = pred_taken_dstage_q;
    target_dstage_d     = target_dstage_q;

    if (mispredict) begin
      // The killed fetch slot moves into D without a prediction attached.
      pc_d                = redirect_pc;
      pc_dstage_d         = pc_q;
      pred_taken_dstage_d = 1'b0;
      target_dstage_d     = pred_target;
    end else if (!bus.stall) begin
      pc_d                = pred_taken ? {pred_target, 2'b00} : pc_q + 32'd4;
      pc_dstage_d         = pc_q;
      pred_taken_dstage_d = pred_taken;
      target_dstage_d     = pred_target;
    end
  end

  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_data_d  = btb_data_q;
    if (btb_we) begin
      btb_valid_d[update_idx]       = 1'b1;
      btb_data_d[update_idx].tag    = update_tag;
      btb_data_d[update_idx].target = bus.resolve_target[31:2];
    end
  end

  always_comb begin
    mispredict_count_d = mispredict_count_q;
    resolve_count_d    = resolve_count_q;
    if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
    if (bus.resolve_valid && (resolve_count_q != 32'hFFFF_FFFF)) begin
      resolve_count_d = resolve_count_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q                <= RESET_PC;
      pc_dstage_q         <= '0;
      pred_taken_dstage_q <= 1'b0;
      target_dstage_q     <= '0;
      mispredict_count_q  <= '0;
      resolve_count_q     <= '0;
      btb_valid_q         <= '0;
    end else begin
      pc_q                <= pc_d;
      pc_dstage_q         <= pc_dstage_d;
      pred_taken_dstage_q <= pred_taken_dstage_d;
      target_dstage_q     <= target_dstage_d;
      mispredict_count_q  <= mispredict_count_d;
      resolve_count_q     <= resolve_count_d;
      btb_valid_q         <= btb_valid_d;
    end
    // NOTE: only the valid bits are reset; tag/target payload is never read
    // while its valid bit is clear, so it stays plain unreset storage.
    btb_data_q <= btb_data_d;
  end

  assign bus.pc               = pc_q;
  assign bus.btb_hit          = btb_hit;
  assign bus.pred_taken_d     = pred_taken_dstage_q;
  assign bus.flush            = mispredict && !reset;
  assign bus.mispredict_count = mispredict_count_q;
  assign bus.resolve_count    = resolve_count_q;

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Directed bench for fetch_pc_redirect: walks one continuous fetch trace with
// hand-computed PCs, BTB contents and counter values.
module tb_fetch_pc_redirect;

  logic clk;
  logic reset;
  int   test_count;
  int   fail_count;
  int   exp_mis;
  int   exp_res;

  fetch_pc_redirect_if dut_if ();

  fetch_pc_redirect #(
    .BTB_IDX_W(6),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_resolve(input logic v, input logic t, input logic [31:0] tgt);
    dut_if.resolve_valid  = v;
    dut_if.resolve_taken  = t;
    dut_if.resolve_target = tgt;
  endtask

  // Forces a taken-mispredict redirect from whatever is in D.
  task automatic jump_to(input logic [31:0] tgt);
    set_resolve(1'b1, 1'b1, tgt);
    tick();
    set_resolve(1'b0, 1'b0, 32'h0);
    exp_mis++;
    exp_res++;
  endtask

  task automatic check_counts(input string name);
    test_count++;
    if (dut_if.mispredict_count !== 32'(exp_mis)) begin
      fail_count++;
      $display("FAIL %s_mis: got %0d, want %0d", name, dut_if.mispredict_count, exp_mis);
    end
    test_count++;
    if (dut_if.resolve_count !== 32'(exp_res)) begin
      fail_count++;
      $display("FAIL %s_res: got %0d, want %0d", name, dut_if.resolve_count, exp_res);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dut_if.stall          = 1'b0;
    dut_if.branch_predict = 1'b0;
    set_resolve(1'b1, 1'b1, 32'h40);
    tick();
    tick();
    #1;
    test_count++;
    if (dut_if.pc !== 32'h0) begin
      fail_count++; $display("FAIL reset_pc: got %h, want %h", dut_if.pc, 32'h0);
    end
    test_count++;
    if (dut_if.flush !== 1'b0) begin
      fail_count++; $display("FAIL reset_flush: got %b, want 0", dut_if.flush);
    end
    test_count++;
    if (dut_if.pred_taken_d !== 1'b0) begin
      fail_count++; $display("FAIL reset_ptd: got %b, want 0", dut_if.pred_taken_d);
    end
    test_count++;
    if (dut_if.btb_hit !== 1'b0) begin
      fail_count++; $display("FAIL reset_hit: got %b, want 0", dut_if.btb_hit);
    end
    check_counts("reset");
    set_resolve(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 3; i++) begin
      tick();
      test_count++;
      if (dut_if.pc !== 32'(i * 4)) begin
        fail_count++; $display("FAIL run_pc%0d: got %h, want %h", i, dut_if.pc, 32'(i * 4));
      end
      test_count++;
      if (dut_if.btb_hit !== 1'b0 || dut_if.flush !== 1'b0) begin
        fail_count++;
        $display("FAIL run_hit_flush%0d: got %b/%b, want 0/0", i, dut_if.btb_hit, dut_if.flush);
      end
    end
    check_counts("run");
  endtask

  task automatic test_mispredict_taken();
    tick();
    tick();
    set_resolve(1'b1, 1'b1, 32'h80);
    #1;
    test_count++;
    if (dut_if.flush !== 1'b1) begin
      fail_count++; $display("FAIL mp_flush: got %b, want 1", dut_if.flush);
    end
    tick();
    set_resolve(1'b0, 1'b0, 32'h0);
    exp_mis++;
    exp_res++;
    test_count++;
    if (dut_if.pc !== 32'h80) begin
      fail_count++; $display("FAIL mp_pc: got %h, want %h", dut_if.pc, 32'h80);
    end
    check_counts("mp");
    jump_to(32'h10);
    dut_if.branch_predict = 1'b1;
    #1;
    test_count++;
    if (dut_if.btb_hit !== 1'b1) begin
      fail_count++; $display("FAIL mp_rehit: got %b, want 1", dut_if.btb_hit);
    end
    tick();
    dut_if.branch_predict = 1'b0;
    test_count++;
    if (dut_if.pc !== 32'h80) begin
      fail_count++; $display("FAIL mp_predpc: got %h, want %h", dut_if.pc, 32'h80);
    end
    test_count++;
    if (dut_if.pred_taken_d !== 1'b1) begin
      fail_count++; $display("FAIL mp_ptd: got %b, want 1", dut_if.pred_taken_d);
    end
  endtask

  task automatic test_not_taken();
    set_resolve(1'b1, 1'b0, 32'h0);
    #1;
    test_count++;
    if (dut_if.flush !== 1'b1) begin
      fail_count++; $display("FAIL nt_flush: got %b, want 1", dut_if.flush);
    end
    tick();
    set_resolve(1'b0, 1'b0, 32'h0);
    exp_mis++;
    exp_res++;
    test_count++;
    if (dut_if.pc !== 32'h14) begin
      fail_count++; $display("FAIL nt_pc: got %h, want %h", dut_if.pc, 32'h14);
    end
    check_counts("nt");
    jump_to(32'h10);
    #1;
    test_count++;
    if (dut_if.btb_hit !== 1'b1) begin
      fail_count++; $display("FAIL nt_still_valid: got %b, want 1", dut_if.btb_hit);
    end
  endtask

  task automatic test_correct_taken();
    dut_if.branch_predict = 1'b1;
    tick();
    dut_if.branch_predict = 1'b0;
    set_resolve(1'b1, 1'b1, 32'h80);
    #1;
    test_count++;
    if (dut_if.flush !== 1'b0) begin
      fail_count++; $display("FAIL ok_flush: got %b, want 0", dut_if.flush);
    end
    tick();
    set_resolve(1'b0, 1'b0, 32'h0);
    exp_res++;
    test_count++;
    if (dut_if.pc !== 32'h84) begin
      fail_count++; $display("FAIL ok_pc: got %h, want %h", dut_if.pc, 32'h84);
    end
    check_counts("ok");
  endtask

  task automatic test_target_mismatch();
    jump_to(32'h10);
    dut_if.branch_predict = 1'b1;
    tick();
    dut_if.branch_predict = 1'b0;
    set_resolve(1'b1, 1'b1, 32'h90);
    #1;
    test_count++;
    if (dut_if.flush !== 1'b1) begin
      fail_count++; $display("FAIL tm_flush: got %b, want 1", dut_if.flush);
    end
    tick();
    set_resolve(1'b0, 1'b0, 32'h0);
    exp_mis++;
    exp_res++;
    test_count++;
    if (dut_if.pc !== 32'h90) begin
      fail_count++; $display("FAIL tm_pc: got %h, want %h", dut_if.pc, 32'h90);
    end
    check_counts("tm");
    jump_to(32'h10);
    dut_if.branch_predict = 1'b1;
    tick();
    dut_if.branch_predict = 1'b0;
    test_count++;
    if (dut_if.pc !== 32'h90) begin
      fail_count++; $display("FAIL tm_btb_updated: got %h, want %h", dut_if.pc, 32'h90);
    end
  endtask

  task automatic test_stall();
    jump_to(32'h20);
    jump_to(32'h10);
    dut_if.branch_predict = 1'b1;
    tick();
    dut_if.branch_predict = 1'b0;
    dut_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      test_count++;
      if (dut_if.pc !== 32'h20 || dut_if.pred_taken_d !== 1'b1) begin
        fail_count++;
        $display("FAIL stall_hold%0d: got pc %h ptd %b, want pc %h ptd 1",
                 i, dut_if.pc, dut_if.pred_taken_d, 32'h20);
      end
    end
    set_resolve(1'b1, 1'b1, 32'h40);
    #1;
    test_count++;
    if (dut_if.flush !== 1'b1) begin
      fail_count++; $display("FAIL stall_flush: got %b, want 1", dut_if.flush);
    end
    tick();
    set_resolve(1'b0, 1'b0, 32'h0);
    exp_mis++;
    exp_res++;
    test_count++;
    if (dut_if.pc !== 32'h40) begin
      fail_count++; $display("FAIL stall_redirect: got %h, want %h", dut_if.pc, 32'h40);
    end
    test_count++;
    if (dut_if.pred_taken_d !== 1'b0) begin
      fail_count++; $display("FAIL stall_ptd_kill: got %b, want 0", dut_if.pred_taken_d);
    end
    dut_if.stall = 1'b0;
    check_counts("stall");
  endtask

  task automatic test_alias_wrap();
    jump_to(32'h110);
    dut_if.branch_predict = 1'b1;
    #1;
    test_count++;
    if (dut_if.btb_hit !== 1'b0) begin
      fail_count++; $display("FAIL alias_hit: got %b, want 0", dut_if.btb_hit);
    end
    tick();
    dut_if.branch_predict = 1'b0;
    test_count++;
    if (dut_if.pc !== 32'h114) begin
      fail_count++; $display("FAIL alias_pc: got %h, want %h", dut_if.pc, 32'h114);
    end
    jump_to(32'hFFFF_FFFC);
    test_count++;
    if (dut_if.pc !== 32'hFFFF_FFFC || dut_if.btb_hit !== 1'b0) begin
      fail_count++;
      $display("FAIL wrap_start: got pc %h hit %b, want pc %h hit 0", dut_if.pc, dut_if.btb_hit, 32'hFFFF_FFFC);
    end
    tick();
    test_count++;
    if (dut_if.pc !== 32'h0) begin
      fail_count++; $display("FAIL wrap_pc: got %h, want %h", dut_if.pc, 32'h0);
    end
    check_counts("wrap");
  endtask

  task automatic test_reset_mid_redirect();
    set_resolve(1'b1, 1'b1, 32'h200);
    reset = 1'b1;
    #1;
    test_count++;
    if (dut_if.flush !== 1'b0) begin
      fail_count++; $display("FAIL rst_mid_flush: got %b, want 0", dut_if.flush);
    end
    tick();
    set_resolve(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    exp_mis = 0;
    exp_res = 0;
    test_count++;
    if (dut_if.pc !== 32'h0) begin
      fail_count++; $display("FAIL rst_mid_pc: got %h, want %h", dut_if.pc, 32'h0);
    end
    check_counts("rst_mid");
    for (int i = 0; i < 5; i++) tick();
    test_count++;
    if (dut_if.pc !== 32'h14 || dut_if.btb_hit !== 1'b0) begin
      fail_count++;
      $display("FAIL rst_btb_clear: got pc %h hit %b, want pc %h hit 0", dut_if.pc, dut_if.btb_hit, 32'h14);
    end
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    exp_mis    = 0;
    exp_res    = 0;
    test_reset();
    test_free_run();
    test_mispredict_taken();
    test_not_taken();
    test_correct_taken();
    test_target_mismatch();
    test_stall();
    test_alias_wrap();
    test_reset_mid_redirect();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/fetch_pc_redirect.md
Name: fetch_pc_redirect

Overview:
Fetch-stage next-PC generator that drives the PC seen by the PC-indexed 2-bit-counter branch predictor and consumes its prediction. It holds a direct-mapped branch target buffer (BTB) and registers each fetch's prediction for one cycle so the execute-stage outcome can be checked against it. On a mispredict it redirects the PC and flushes the wrong-path fetch. It also keeps accuracy counters.

Parameters:
BTB_IDX_W, 6, log2 of BTB entries (64 entries); index = pc[BTB_IDX_W+1:2]
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold fetch PC and the D-stage registers
branch_predict  in  1  predictor's taken/not-taken for the current pc
pc  out  32  current fetch PC (feeds predictor pc)
btb_hit  out  1  current pc hits a valid BTB entry (feeds predictor branch)
pred_taken_d  out  1  registered prediction of D-stage instruction (feeds predictor branch_o_delayed)
resolve_valid  in  1  D-stage instruction is a resolved branch this cycle
resolve_taken  in  1  actual branch outcome
resolve_target  in  32  actual taken target
flush  out  1  kill the instruction currently in fetch
mispredict_count  out  32  saturating mispredict count
resolve_count  out  32  saturating resolved-branch count

Behaviour:
- Reset values: pc=RESET_PC; every BTB valid bit=0; pc_d=0; pred_taken_d=0; flush=0; both counters=0. Reset takes priority over all other inputs, including mid-redirect.
- BTB entry fields: valid, tag=pc[31:BTB_IDX_W+2], target[31:2]. Lookup is combinational on pc. btb_hit = valid & tag match.
- pred_taken = btb_hit & branch_predict. pred_target = BTB target with bits [1:0]=00.
- D-stage registers (pc_d, pred_taken_d, target_d) load {pc, pred_taken, pred_target} on each non-stalled cycle. They hold while stall=1.
- Mispredict condition: mispredict = resolve_valid & (resolve_taken != pred_taken_d). It also fires if resolve_taken = pred_taken_d = 1 and {resolve_target[31:2],2'b00} != target_d.
- Redirect target:
  - resolve_taken=1: {resolve_target[31:2],2'b00}.
  - resolve_taken=0: pc_d+4.
- Next-PC priority: reset > mispredict (redirect target) > stall (hold) > pred_taken (pred_target) > pc+4.
  - Mispredict overrides stall.
  - pc+4 wraps mod 2^32 (32'hFFFF_FFFC -> 0).
- flush is combinational and equals mispredict, gated to 0 during reset.
- On mispredict, the D-stage registers load pred_taken_d=0 and pc_d=pc (the flushed slot), so the killed instruction is never resolved as predicted.
- BTB update happens on clock edges where resolve_valid & resolve_taken & !reset:
  - entry[pc_d index] <= {valid=1, tag(pc_d), resolve_target[31:2]}.
  - Not-taken outcomes never invalidate an entry.
- Same-cycle update and lookup of the same index: the lookup sees the old contents; the new entry is visible next cycle.
- Counters:
  - resolve_count increments on each resolve_valid.
  - mispredict_count increments on each mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- Latency: prediction to PC change is 0 cycles (next edge). Resolve to redirect PC is 1 edge, with flush high in the resolve cycle.
- Implementation: one clocked always block for state; next-PC and flush logic are combinational. BTB storage is a register array with synchronous reset of valid bits only.

Test Plan:
- Reset, then 4 free-running cycles with stall=0, no BTB hits -> pc = 0,4,8,12; btb_hit=0; flush=0; counters 0.
- Resolve taken at pc_d=0x10, target 0x80 (pred_taken_d=0) -> flush=1 that cycle; next pc=0x80; mispredict_count=1; resolve_count=1. When pc returns to 0x10 with branch_predict=1 -> btb_hit=1, next pc=0x80.
- BTB hit with branch_predict=1 at 0x10, later resolve not-taken -> flush=1; next pc=0x14; BTB entry still valid.
- Correct taken prediction (target matches) -> flush=0; resolve_count increments, mispredict_count unchanged. Same case with resolve_target=0x90 vs stored 0x80 -> flush, pc=0x90, BTB updated.
- stall=1 for 3 cycles at pc=0x20 -> pc and pred_taken_d hold. Mispredict asserted during the stall -> redirect still taken.
- Aliasing: install 0x10->0x80, then fetch 0x110 (same index, different tag) -> btb_hit=0. pc=0xFFFF_FFFC with no hit -> next pc=0. Assert reset mid-redirect -> pc=RESET_PC, flush=0.
